// File: rtl/bus_arbiter.sv
// Arbitrates the IF fetch port and MEM data port onto one single-beat req/ack bus,
// latching read data per port and raising stall requests until each access completes.
module bus_arbiter #(
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        i_ce_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        stallreq_if_o,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        stallreq_mem_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t          state_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [SW-1:0]   bus_sel_q;
  logic [AW-1:0]   bus_addr_q;
  logic [DW-1:0]   bus_wdata_q;
  logic [DW-1:0]   i_rdata_q;
  logic [DW-1:0]   d_rdata_q;
  logic            i_hold_q;
  logic            d_hold_q;
  logic            discard_q;
  logic            last_i_q;   // 1 = fetch port was granted last

  logic            i_pend;
  logic            d_pend;
  logic            pick_d;
  logic            unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:1]};

  assign i_pend = i_ce_i & ~i_hold_q & ~flush_i;
  assign d_pend = d_ce_i & ~d_hold_q;
  // Data wins outright with D_PRIORITY, otherwise only when fetch was granted last
  assign pick_d = d_pend & (D_PRIORITY | ~i_pend | last_i_q);

  assign stallreq_if_o  = i_pend;
  assign stallreq_mem_o = d_pend;

  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_hold_q    <= 1'b0;
      d_hold_q    <= 1'b0;
      discard_q   <= 1'b0;
      last_i_q    <= 1'b0;
    end else begin
      // Hold release first so a completing ack below overrides it
      if (!stall_i[0] || flush_i) i_hold_q <= 1'b0;
      if (!stall_i[4])            d_hold_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_q     <= D_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= d_we_i;
            bus_sel_q   <= d_sel_i;
            bus_addr_q  <= d_addr_i;
            bus_wdata_q <= d_wdata_i;
            last_i_q    <= 1'b0;
          end else if (i_pend) begin
            state_q     <= I_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= SW'(4'b1111);
            bus_addr_q  <= i_addr_i;
            bus_wdata_q <= '0;
            last_i_q    <= 1'b1;
          end
        end
        I_BUSY: begin
          if (bus_ack_i) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            if (discard_q || flush_i) begin
              discard_q <= 1'b0;
            end else begin
              i_rdata_q <= bus_rdata_i;
              i_hold_q  <= 1'b1;
            end
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end
        D_BUSY: begin
          if (bus_ack_i) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            d_rdata_q <= bus_rdata_i;
            d_hold_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one external memory bus between the IF-stage instruction port and the MEM-stage data port.
- Sequences single-beat req/ack transactions on that bus and latches the read data for each port.
- Raises per-stage stall requests into ctrl until each port's access has completed.
- Sits between pc_reg/if_fd, mem, ctrl and the bus slave; replaces the direct rom_addr_o/rom_ce_o connection.

Parameters:
- D_PRIORITY, 1, 1 = the data port always wins arbitration; 0 = round-robin (the port granted last loses a tie).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- stall_i  in  6  pipeline stall vector from ctrl; bit0 = PC, bit4 = MEM
- flush_i  in  1  pipeline flush; cancels a pending or in-flight fetch
- i_ce_i  in  1  fetch request from pc_reg
- i_addr_i  in  32  fetch address
- i_rdata_o  out  32  fetched instruction
- stallreq_if_o  out  1  fetch not yet complete
- d_ce_i  in  1  data access request from mem
- d_we_i  in  1  1 = store
- d_sel_i  in  4  byte enables
- d_addr_i  in  32  data address
- d_wdata_i  in  32  store data
- d_rdata_o  out  32  load data
- stallreq_mem_o  out  1  data access not yet complete
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  32  bus address
- bus_wdata_o  out  32  bus write data
- bus_rdata_i  in  32  bus read data, valid with ack
- bus_ack_i  in  1  one-cycle completion strobe from the slave

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE; all outputs, the hold flags, the discard flag and the last-grant register clear to 0.
  - A transfer in flight is abandoned; any later ack is ignored until a new launch.
- Stall requests (combinational):
  - stallreq_if_o = i_ce_i & ~i_hold & ~flush_i.
  - stallreq_mem_o = d_ce_i & ~d_hold.
- FSM states: IDLE, I_BUSY, D_BUSY.
- IDLE:
  - d_pend = d_ce_i & ~d_hold; i_pend = i_ce_i & ~i_hold & ~flush_i.
  - If both are pending, D_PRIORITY=1 picks D. D_PRIORITY=0 picks the port not granted last.
  - Launch registers bus_req_o=1 and the address/we/sel/wdata for the next cycle.
  - Fetches drive we=0 and sel=4'b1111.
  - The state moves to I_BUSY or D_BUSY and the last-grant register updates.
  - Launch latency is 1 cycle from request to bus_req_o.
- *_BUSY:
  - Bus outputs are held stable until bus_ack_i==1.
  - At the ack edge: bus_req_o drops to 0 and the state returns to IDLE.
  - The ack cycle itself does not launch; at least 1 idle bus cycle separates transfers.
  - At the ack edge the port's rdata_o takes bus_rdata_i (stores also capture it) and the port's hold flag is set, unless the fetch is discarded.
- Hold flags:
  - A set hold flag keeps the stall request low and holds rdata_o until the stage advances.
  - d_hold clears at an edge where stall_i[4]==0.
  - i_hold clears at an edge where stall_i[0]==0 or flush_i==1.
  - If the same edge both sets and clears a hold flag, set wins.
- Flush:
  - flush_i in IDLE suppresses a fetch launch.
  - flush_i in I_BUSY sets the discard flag. The transfer still completes on the bus, because the slave handshake is never aborted.
  - At the ack of a discarded fetch, i_rdata_o and i_hold stay unchanged and discard clears.
  - flush_i has no effect on data transfers.
- Bus rules:
  - Exactly one transaction is outstanding.
  - An ack arriving in IDLE is ignored.
  - Zero-wait-state slaves (ack in the first req cycle) give a 3-cycle turnaround: launch, ack, idle.
- Address/data are taken from inputs at the launch edge only; later input changes do not affect the transfer.

Test Plan:
- Single fetch, ack after 2 wait cycles:
  - i_ce_i=1, addr 0x100, rdata 0x3401_0020.
  - bus_req_o high 3 cycles; stallreq_if_o drops the cycle after ack; i_rdata_o=0x3401_0020 held while stall_i[0]=1.
- Simultaneous requests, D_PRIORITY=1, store d_addr 0x8, sel 4'b0011, wdata 0xDEAD_BEEF:
  - Data transaction goes first with we=1/sel=0011.
  - The fetch launches only after the idle cycle.
  - stallreq_mem_o clears before stallreq_if_o.
- D_PRIORITY=0, both ports requesting continuously with hold flags cleared each cycle:
  - Grants alternate I,D,I,D after reset; the first grant goes to I (last-grant=0 ⇒ D was last).
- Flush mid-fetch:
  - flush_i pulsed in I_BUSY, then ack with 0x1234_5678.
  - i_rdata_o retains its old value, i_hold=0, and the next fetch launches normally.
- Reset mid-transfer:
  - rst=0 while in D_BUSY, then an ack arrives after reset.
  - All outputs are 0 and the stray ack is ignored (d_rdata_o stays 0, state IDLE).
- Hold release:
  - Load completes with stall_i[4]=1 held for 4 cycles and d_ce_i kept high.
  - No relaunch occurs; the next load launches only after stall_i[4]=0.
